snell_solver: RTL and testbench
===============================

Name: snell_solver

Overview:
Parametrised, handshaked successor to the fixed-width Snell's-law block. It computes n1 = n2 * sin(theta2) / sin(theta1) in unsigned fixed point, using a sine ROM, one multiply and a multi-cycle restoring divider. The result has a fractional part, saturates on overflow, and flags illegal inputs. It sits between the optics parameter registers and downstream consumers, with valid/ready on both sides.

Parameters:
N_W, 4, integer width of n2 and of the integer part of n1
ANG_W, 7, angle width in whole degrees; legal range 0..90
FRAC_W, 4, fractional bits of n1 (n1 is Q(N_W).(FRAC_W))
SIN_W, 12, sine ROM precision; entry = round(sin(deg)*2^SIN_W), stored in SIN_W+1 bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset: sampled on rising clk; 0 = reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
n2  in  N_W  refractive index of medium 2, integer
theeta1  in  ANG_W  angle in medium 1, degrees
theeta2  in  ANG_W  angle in medium 2, degrees
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
n1  out  N_W+FRAC_W  result, Q(N_W).(FRAC_W), floor-truncated
sat  out  1  result was clipped to all-ones
err  out  1  illegal input: theeta1==0, or either angle >90

Behaviour:
- Reset (rst==0 at an edge): state=IDLE, in_ready=1, out_valid=0, n1=0, sat=0, err=0. Reset overrides any operation in progress, including mid-DIV and DONE; the pending result is discarded.
- in_ready = (state==IDLE). A request is accepted on an edge where in_valid&&in_ready; n2 and both angles are registered at that edge (call it edge k).
- FSM: IDLE -> LUT -> MUL -> DIV -> DONE -> IDLE.
- IDLE: on accept, go to LUT.
- LUT (1 cycle): read s1=sin(theeta1) and s2=sin(theeta2) from the ROM. If theeta1==0, or theeta1>90, or theeta2>90: set err=1, n1=0, sat=0, and go to DONE at edge k+1.
- MUL (1 cycle): P = n2*s2, width N_W+SIN_W+1. The dividend is P<<FRAC_W, width D = N_W+SIN_W+1+FRAC_W.
- DIV: restoring divide by s1, one quotient bit per cycle, exactly D cycles. The quotient is D bits wide, floor.
- Saturation: if any quotient bit at or above N_W+FRAC_W is set, n1 = all ones and sat=1. Otherwise n1 = quotient[N_W+FRAC_W-1:0] and sat=0.
- Latency: for a legal request, out_valid rises after edge k+2+D (23 cycles at defaults). For an err request it rises after edge k+1. Latency is data-independent.
- DONE: out_valid=1. n1, sat and err hold stable while out_ready==0. On an edge with out_ready==1, go to IDLE and clear out_valid. in_ready rises in the same cycle.
- No new request is accepted while out_valid==1; there is no overlap.
- theeta2==0 with a legal theeta1 gives n1=0, err=0.
- in_valid while busy is ignored, and the inputs are not sampled.

Decomposition:
- Shared package snell_pkg holds:
  - FSM state encoding (IDLE, LUT, MUL, DIV, DONE)
  - ANG_MAX=90
  - the derived dividend-width expression
  - the sine table generation function
- Sub-module snell_sin_lut: 91-entry ROM with two combinational read ports, indexed by angle and parametrised by SIN_W. The out-of-range check stays in the parent.
- The divider stays inline in the FSM, with no separate module.

Test Plan:
- Legacy case: n2=10, theeta1=3, theeta2=3, out_ready=1 -> after 23 cycles n1=8'hA0 (10.0), sat=0, err=0.
- Fraction: n2=1, theeta1=30, theeta2=90 (s1=2048, s2=4096) -> n1=8'h20 (2.0). Then n2=3, theeta1=90, theeta2=30 -> n1=8'h18 (1.5).
- Saturation: n2=15, theeta1=1, theeta2=90 -> n1=8'hFF, sat=1, err=0, still 23-cycle latency.
- Errors:
  - theeta1=0 -> out_valid after 2 edges, err=1, n1=0.
  - theeta2=91 with n2=5, theeta1=45 -> err=1, n1=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> n1/sat/err stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> one-cycle handoff, then in_ready=1.
- Reset mid-op: drive rst=0 for one edge during DIV cycle 5 -> next cycle in_ready=1, out_valid=0, n1=0. A fresh request (n2=10, theeta1=theeta2=3) then returns 8'hA0.

Source files
------------

// File: rtl/snell_pkg.sv
// rtl/snell_pkg.sv - shared FSM encoding, constants and sine-table helper for snell_solver
// No ports: package imported by snell_solver and snell_sin_lut.
package snell_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LUT,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

  // Largest legal angle in whole degrees; the ROM holds entries 0..ANG_MAX.
  localparam int ANG_MAX = 90;

  // Dividend width: product n2*sin (N_W+SIN_W+1 bits) shifted left by FRAC_W.
  function automatic int div_width(int n_w, int sin_w, int frac_w);
    return n_w + sin_w + 1 + frac_w;
  endfunction

  // round(sin(deg)*2^sin_w); sin(90) needs sin_w+1 bits.
  function automatic int sin_entry(int deg, int sin_w);
    real rad;
    real scaled;
    rad    = real'(deg) * 3.14159265358979323846 / 180.0;
    scaled = $sin(rad) * (2.0 ** sin_w);
    return $rtoi(scaled + 0.5);
  endfunction

endpackage

// File: rtl/snell_sin_lut.sv
// rtl/snell_sin_lut.sv - 91-entry sine ROM with two combinational read ports
// Ports:
//   ang_a, ang_b : angle in whole degrees
//   sin_a, sin_b : round(sin(angle)*2^SIN_W); zero for angles past ANG_MAX
module snell_sin_lut
  import snell_pkg::*;
#(
  parameter int ANG_W = 7,
  parameter int SIN_W = 12
) (
  input  logic [ANG_W-1:0] ang_a,
  input  logic [ANG_W-1:0] ang_b,
  output logic [SIN_W:0]   sin_a,
  output logic [SIN_W:0]   sin_b
);

  logic [SIN_W:0] rom [0:ANG_MAX];

  for (genvar g = 0; g <= ANG_MAX; g++) begin : g_rom
    assign rom[g] = (SIN_W+1)'(sin_entry(g, SIN_W));
  end

  // Out-of-range addresses return zero; the parent flags them as errors.
  always_comb begin
    sin_a = '0;
    sin_b = '0;
    if (int'(ang_a) <= ANG_MAX) sin_a = rom[ang_a];
    if (int'(ang_b) <= ANG_MAX) sin_b = rom[ang_b];
  end

endmodule

// File: rtl/snell_solver.sv
// rtl/snell_solver.sv - handshaked fixed-point Snell's-law solver n1 = n2*sin(t2)/sin(t1)
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   in_valid/in_ready     : request handshake; n2, theeta1, theeta2 sampled on accept
//   out_valid/out_ready   : result handshake; n1 (Q(N_W).(FRAC_W)), sat, err held in DONE
module snell_solver #(
  parameter int N_W    = 4,
  parameter int ANG_W  = 7,
  parameter int FRAC_W = 4,
  parameter int SIN_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_W-1:0]        n2,
  input  logic [ANG_W-1:0]      theeta1,
  input  logic [ANG_W-1:0]      theeta2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_W+FRAC_W-1:0] n1,
  output logic                  sat,
  output logic                  err
);
  import snell_pkg::*;

  localparam int D  = div_width(N_W, SIN_W, FRAC_W);
  localparam int PW = N_W + SIN_W + 1;
  localparam int NW = N_W + FRAC_W;
  localparam int CW = $clog2(D);
  localparam logic [ANG_W-1:0] ANG_LIM = ANG_W'(ANG_MAX);

  state_t           state_q, state_d;
  logic [N_W-1:0]   n2_q, n2_d;
  logic [ANG_W-1:0] t1_q, t1_d;
  logic [ANG_W-1:0] t2_q, t2_d;
  logic [SIN_W:0]   s1_q, s1_d;
  logic [SIN_W:0]   s2_q, s2_d;
  logic [SIN_W:0]   rem_q, rem_d;
  logic [D-1:0]     quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    n1_q, n1_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;

  logic [SIN_W:0]   rom_s1, rom_s2;
  logic [PW-1:0]    prod;
  logic [SIN_W+1:0] rem_shift;
  logic             rem_ge;

  snell_sin_lut #(
    .ANG_W (ANG_W),
    .SIN_W (SIN_W)
  ) u_lut (
    .ang_a (t1_q),
    .ang_b (t2_q),
    .sin_a (rom_s1),
    .sin_b (rom_s2)
  );

  always_comb begin
    state_d = state_q;
    n2_d    = n2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    sat_d   = sat_q;
    err_d   = err_q;

    prod = PW'(n2_q) * PW'(s2_q);

    // Restoring step: quo_q shifts the dividend out MSB-first while
    // quotient bits shift in at the bottom. Remainder stays below s1.
    rem_shift = {rem_q, quo_q[D-1]};
    rem_ge    = (rem_shift >= {1'b0, s1_q});

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          n2_d    = n2;
          t1_d    = theeta1;
          t2_d    = theeta2;
          state_d = ST_LUT;
        end
      end
      ST_LUT: begin
        s1_d = rom_s1;
        s2_d = rom_s2;
        if (t1_q == '0 || t1_q > ANG_LIM || t2_q > ANG_LIM) begin
          err_d   = 1'b1;
          n1_d    = '0;
          sat_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        quo_d   = {prod, {FRAC_W{1'b0}}};
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_DIV;
      end
      ST_DIV: begin
        quo_d = {quo_q[D-2:0], rem_ge};
        rem_d = rem_ge ? (SIN_W+1)'(rem_shift - {1'b0, s1_q}) : rem_shift[SIN_W:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(D-1)) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
          if (|quo_d[D-1:NW]) begin
            n1_d  = '1;
            sat_d = 1'b1;
          end else begin
            n1_d  = quo_d[NW-1:0];
            sat_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      n2_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      n1_q    <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n2_q    <= n2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      n1_q    <= n1_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign n1        = n1_q;
  assign sat       = sat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_snell_solver.sv
// tb/tb_snell_solver.sv - scoreboard bench for snell_solver
`timescale 1ns/1ps
module tb_snell_solver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] n2 = '0;
  logic [6:0] theeta1 = '0;
  logic [6:0] theeta2 = '0;
  logic       in_ready, out_valid, sat, err;
  logic [7:0] n1;

  int errors = 0;
  int checks = 0;
  int lat;

  typedef struct {
    logic [7:0] n1;
    logic       sat;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int n2; int t1; int t2; int n1; int sat; int err; int lat;
  } case_t;

  // Expected values worked by hand from round(sin*4096):
  // s(1)=71, s(3)=214, s(30)=2048, s(90)=4096.
  case_t tbl [0:12] = '{
    '{10,  3,  3, 'hA0, 0, 0, 23},
    '{ 1, 30, 90, 'h20, 0, 0, 23},
    '{ 3, 90, 30, 'h18, 0, 0, 23},
    '{15,  1, 90, 'hFF, 1, 0, 23},
    '{ 5,  0, 45, 'h00, 0, 1,  1},
    '{ 5, 45, 91, 'h00, 0, 1,  1},
    '{ 5, 91, 45, 'h00, 0, 1,  1},
    '{ 9, 60,  0, 'h00, 0, 0, 23},
    '{ 8, 30, 90, 'hFF, 1, 0, 23},
    '{ 7, 30, 90, 'hE0, 0, 0, 23},
    '{15, 90, 90, 'hF0, 0, 0, 23},
    '{ 0, 45, 45, 'h00, 0, 0, 23},
    '{ 6, 90, 90, 'h60, 0, 0, 23}
  };

  always #5 clk = ~clk;

  snell_solver dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n2        (n2),
    .theeta1   (theeta1),
    .theeta2   (theeta2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n1        (n1),
    .sat       (sat),
    .err       (err)
  );

  // Drives one request from a negedge, pushes its expectation, returns at the
  // negedge after the accepting edge with lat cleared.
  task automatic issue(input logic [3:0] a, input logic [6:0] b, input logic [6:0] c,
                       input logic [7:0] en1, input logic esat, input logic eerr, input int elat);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n2       = a;
    theeta1  = b;
    theeta2  = c;
    in_valid = 1'b1;
    sb.push_back('{en1, esat, eerr, elat});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
  endtask

  task automatic wait_out();
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (n1 !== 8'h00) begin errors++; $display("FAIL reset_n1 got=%h want=00", n1); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b want=0", sat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_table();
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      issue(4'(tbl[i].n2), 7'(tbl[i].t1), 7'(tbl[i].t2), 8'(tbl[i].n1),
            1'(tbl[i].sat), 1'(tbl[i].err), tbl[i].lat);
      wait_out();
      e = sb.pop_front();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL case%0d_timeout out_valid=%b want=1", i, out_valid); end
      checks++; if (n1 !== e.n1) begin errors++; $display("FAIL case%0d_n1 got=%h want=%h", i, n1, e.n1); end
      checks++; if (sat !== e.sat) begin errors++; $display("FAIL case%0d_sat got=%b want=%b", i, sat, e.sat); end
      checks++; if (err !== e.err) begin errors++; $display("FAIL case%0d_err got=%b want=%b", i, err, e.err); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL case%0d_latency got=%0d want=%0d", i, lat, e.lat); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL case%0d_handoff in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    issue(4'd10, 7'd3, 7'd3, 8'hA0, 1'b0, 1'b0, 23);
    wait_out();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout out_valid=%b want=1", out_valid); end
    checks++; if (n1 !== e.n1 || lat !== e.lat) begin
      errors++; $display("FAIL bp_result n1=%h lat=%0d want n1=%h lat=%0d", n1, lat, e.n1, e.lat);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        in_valid = 1'b1;
        n2       = 4'd15;
        theeta1  = 7'd1;
        theeta2  = 7'd90;
      end
      @(negedge clk);
      checks++; if (n1 !== e.n1 || sat !== e.sat || err !== e.err || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d n1=%h sat=%b err=%b ov=%b ir=%b want n1=%h sat=%b err=%b ov=1 ir=0",
                 i, n1, sat, err, out_valid, in_ready, e.n1, e.sat, e.err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_handoff out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ignored out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    out_ready = 1'b1;
    issue(4'd15, 7'd1, 7'd90, 8'hFF, 1'b1, 1'b0, 23);
    e = sb.pop_back();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (n1 !== 8'h00 || sat !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs n1=%h sat=%b err=%b want 00/0/0", n1, sat, err);
    end
    repeat (25) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_discard out_valid=%b want=0", out_valid); end
    issue(4'd10, 7'd3, 7'd3, 8'hA0, 1'b0, 1'b0, 23);
    wait_out();
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_fresh_timeout out_valid=%b want=1", out_valid); end
    checks++; if (n1 !== e.n1 || sat !== e.sat || err !== e.err || lat !== e.lat) begin
      errors++; $display("FAIL midrst_fresh n1=%h sat=%b err=%b lat=%0d want %h/%b/%b/%0d",
                         n1, sat, err, lat, e.n1, e.sat, e.err, e.lat);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_table();
    test_backpressure();
    test_reset_mid_op();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
